// File: rtl/gate_truth_sweeper.sv
// Clocked stimulus and checker for a combinational gate: sweeps every input vector,
// captures the gate's truth table and compares it against an expected table.
module gate_truth_sweeper #(
  parameter int unsigned N_IN        = 2,
  parameter int unsigned HOLD_CYCLES = 10,
  parameter logic [(2**N_IN)-1:0] EXPECTED = 4'b1000
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  output logic [N_IN-1:0]        o_gate_in,
  input  logic                   i_gate_out,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_pass,
  output logic [(2**N_IN)-1:0]   o_truth_table,
  output logic [N_IN:0]          o_mismatch_cnt
);

  localparam int unsigned CntW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(HOLD_CYCLES - 1);
  localparam logic [N_IN-1:0] LastVec = {N_IN{1'b1}};

  typedef enum logic [1:0] {StIdle, StDrive, StDone} state_e;

  state_e                r_state;
  logic [CntW-1:0]       r_cnt;
  logic [N_IN-1:0]       r_gate_in;
  logic [(2**N_IN)-1:0]  r_table;
  logic [N_IN:0]         r_mis;
  logic                  r_busy;
  logic                  r_done;
  logic                  w_miss;

  assign w_miss = (i_gate_out != EXPECTED[r_gate_in]);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_gate_in <= '0;
      r_table   <= '0;
      r_mis     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle, StDone: begin
          if (i_start) begin
            r_state   <= StDrive;
            r_cnt     <= '0;
            r_gate_in <= '0;
            r_table   <= '0;
            r_mis     <= '0;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
          end
        end
        StDrive: begin
          if (r_cnt == LastCnt) begin
            // Last hold cycle: the vector has been stable for HOLD_CYCLES clocks.
            r_table[r_gate_in] <= i_gate_out;
            r_mis              <= r_mis + {{N_IN{1'b0}}, w_miss};
            if (r_gate_in == LastVec) begin
              r_state <= StDone;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_gate_in <= r_gate_in + N_IN'(1);
              r_cnt     <= '0;
            end
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o_gate_in      = r_gate_in;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_truth_table  = r_table;
  assign o_mismatch_cnt = r_mis;
  assign o_pass         = r_done && (r_mis == '0);

endmodule
